// File: rtl/pe_mac_acc.sv
// Convolution PE: TAPS unsigned-by-signed multiplies, a registered reduction, and a multi-beat
// accumulator with bias, optional ReLU and shift/round/saturate requantisation.
module pe_mac_acc #(
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int TAPS  = 25,
    parameter int ACC_W = 32,
    parameter int SH_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic [TAPS*DW-1:0]   in_if,
    input  logic [TAPS*WW-1:0]   in_w,
    input  logic [ACC_W-1:0]     bias,
    input  logic                 relu_en,
    input  logic                 quan_en,
    input  logic [SH_W-1:0]      shift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     pe_out
);

    localparam int PW = DW + WW + 1;
    localparam logic signed [ACC_W:0] U_MAX = (ACC_W+1)'((1 << DW) - 1);
    localparam logic signed [ACC_W:0] S_MAX = (ACC_W+1)'((1 << (DW - 1)) - 1);
    localparam logic signed [ACC_W:0] S_MIN = -S_MAX - 1;

    typedef struct packed {
        logic             first;
        logic             last;
        logic             relu_en;
        logic             quan_en;
        logic [SH_W-1:0]  shift;
        logic [ACC_W-1:0] bias;
    } side_t;

    // Handshake: a beat moves on in_valid && in_ready; a result moves on out_valid && out_ready.
    // A held result (out_valid && !out_ready) freezes every stage, so in_ready drops with it.
    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    side_t                    s_in, s1, s2;
    logic                     v1, v2;
    logic signed [PW-1:0]     prod  [TAPS];
    logic signed [ACC_W-1:0]  mul_d [TAPS];
    logic signed [ACC_W-1:0]  mul_q [TAPS];
    logic signed [ACC_W-1:0]  sum_d, sum_q;
    logic signed [ACC_W-1:0]  acc, acc_n, relu_r;
    logic signed [ACC_W:0]    shifted, q, q_sat;
    logic                     rnd;
    logic        [ACC_W-1:0]  post;
    logic                     load;

    always_comb begin
        s_in         = '0;
        s_in.first   = in_first;
        s_in.last    = in_last;
        s_in.relu_en = relu_en;
        s_in.quan_en = quan_en;
        s_in.shift   = shift;
        s_in.bias    = bias;
    end

    // Activation gets a zero MSB so the product is a plain signed multiply.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod[k]  = PW'($signed({1'b0, in_if[k*DW +: DW]})) * PW'($signed(in_w[k*WW +: WW]));
            mul_d[k] = ACC_W'(prod[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1 <= 1'b0;
            s1 <= '0;
            for (int k = 0; k < TAPS; k++) mul_q[k] <= '0;
        end else if (!stall) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1 <= s_in;
                for (int k = 0; k < TAPS; k++) mul_q[k] <= mul_d[k];
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < TAPS; k++) sum_d = sum_d + mul_q[k];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v2    <= 1'b0;
            s2    <= '0;
            sum_q <= '0;
        end else if (!stall) begin
            v2 <= v1;
            if (v1) begin
                s2    <= s1;
                sum_q <= sum_d;
            end
        end
    end

    // Post-processing works on the would-be accumulator value so the last beat needs no extra stage.
    always_comb begin
        acc_n   = (s2.first ? $signed(s2.bias) : acc) + sum_q;
        relu_r  = (s2.relu_en && acc_n[ACC_W-1]) ? '0 : acc_n;
        shifted = $signed({relu_r[ACC_W-1], relu_r}) >>> s2.shift;
        rnd     = (s2.shift != '0) &&
                  ((relu_r & (ACC_W'(1) << (s2.shift - SH_W'(1)))) != '0);
        q       = shifted + $signed((ACC_W+1)'(rnd));
        if (s2.relu_en) begin
            q_sat = (q > U_MAX) ? U_MAX : q;
        end else if (q > S_MAX) begin
            q_sat = S_MAX;
        end else if (q < S_MIN) begin
            q_sat = S_MIN;
        end else begin
            q_sat = q;
        end
        post = s2.quan_en ? ACC_W'(q_sat) : relu_r;
    end

    assign load = v2 && !stall && s2.last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc       <= '0;
            pe_out    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (v2 && !stall) begin
                if (s2.last) begin
                    acc    <= '0;
                    pe_out <= post;
                end else begin
                    acc <= acc_n;
                end
            end
            if (load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_acc.sv
// Bench for pe_mac_acc: vector table, latency, back-pressure, reset and a narrow-accumulator wrap check.
module tb_pe_mac_acc;

    localparam int DW = 8, WW = 8, TAPS = 25, ACC_W = 32, SH_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                in_valid, in_ready, in_first, in_last;
    logic [TAPS*DW-1:0]  in_if;
    logic [TAPS*WW-1:0]  in_w;
    logic [ACC_W-1:0]    bias;
    logic                relu_en, quan_en;
    logic [SH_W-1:0]     shift;
    logic                out_valid, out_ready;
    logic [ACC_W-1:0]    pe_out;

    logic                in_valid16, in_ready16, out_valid16;
    logic [15:0]         bias16, pe_out16;

    pe_mac_acc #(.DW(DW), .WW(WW), .TAPS(TAPS), .ACC_W(ACC_W), .SH_W(SH_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .in_if(in_if), .in_w(in_w),
        .bias(bias), .relu_en(relu_en), .quan_en(quan_en), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready), .pe_out(pe_out)
    );

    pe_mac_acc #(.DW(DW), .WW(WW), .TAPS(TAPS), .ACC_W(16), .SH_W(SH_W)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_first(1'b1), .in_last(1'b1), .in_if(in_if), .in_w(in_w),
        .bias(bias16), .relu_en(1'b0), .quan_en(1'b0), .shift(5'd0),
        .out_valid(out_valid16), .out_ready(1'b1), .pe_out(pe_out16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [ACC_W-1:0] exp_q[$];

    typedef struct {
        logic        first, last;
        int          a0, w0, fa, fw;
        int          bias;
        logic        relu, quan;
        int          sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic f, input logic l, input int a0, input int w0,
                                input int fa, input int fw, input int b, input logic r,
                                input logic qn, input int sh, input int e);
        vec_t v;
        v.first = f; v.last = l; v.a0 = a0; v.w0 = w0; v.fa = fa; v.fw = fw;
        v.bias = b; v.relu = r; v.quan = qn; v.sh = sh; v.exp = e;
        return v;
    endfunction

    function automatic logic [31:0] model_post(input longint a, input logic relu, input logic qn,
                                               input int sh);
        longint r, q;
        r = (relu && a < 0) ? 64'sd0 : a;
        if (!qn) return r[31:0];
        q = r >>> sh;
        if (sh != 0) q = q + ((r >>> (sh - 1)) & 64'sd1);
        if (relu) begin
            if (q > 255) q = 255;
        end else begin
            if (q > 127) q = 127;
            else if (q < -128) q = -128;
        end
        return q[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h expected none", pe_out);
            end else begin
                check("pe_out", {32'd0, pe_out}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive_beat(input logic f, input logic l, input int a0, input int w0,
                              input int fa, input int fw, input int b, input logic r,
                              input logic qn, input int sh);
        logic ok;
        int   guard;
        for (int k = 0; k < TAPS; k++) begin
            in_if[k*DW +: DW] = (k == 0) ? a0[DW-1:0] : fa[DW-1:0];
            in_w[k*WW +: WW]  = (k == 0) ? w0[WW-1:0] : fw[WW-1:0];
        end
        in_first = f; in_last = l; bias = b; relu_en = r; quan_en = qn; shift = sh[SH_W-1:0];
        in_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            guard++;
            if (guard > 500) begin
                check("beat_accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(name, {63'd0, exp_q.size() != 0 || out_valid}, 64'd0);
    endtask

    task automatic send_pixel_model(input int nb);
        longint acc;
        int a0, w0, fa, fw, b, sh;
        logic r, qn;
        acc = 0;
        for (int i = 0; i < nb; i++) begin
            a0 = $urandom_range(255); w0 = int'($urandom_range(255)) - 128;
            fa = $urandom_range(255); fw = int'($urandom_range(255)) - 128;
            b  = int'($urandom_range(4000)) - 2000;
            sh = $urandom_range(6); r = 1'($urandom_range(1)); qn = 1'($urandom_range(1));
            acc = ((i == 0) ? longint'(b) : acc) + a0 * w0 + (TAPS - 1) * fa * fw;
            if (i == nb - 1) exp_q.push_back(model_post(acc, r, qn, sh));
            drive_beat(i == 0, i == nb - 1, a0, w0, fa, fw, b, r, qn, sh);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int base, g;
        int full16;
        logic [15:0] e16;
        int b_vals[6];

        rst = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_if = '0; in_w = '0; bias = '0; relu_en = 1'b0; quan_en = 1'b0; shift = '0;
        out_ready = 1'b1; in_valid16 = 1'b0; bias16 = '0;

        vecs[0]  = mk(1, 1,   1,    1,   1,    1,     0, 0, 0, 0,      25);
        vecs[1]  = mk(1, 0, 100,    1,   0,    0,     5, 1, 1, 3,       0);
        vecs[2]  = mk(0, 0,  40,   -1,   0,    0,    77, 1, 1, 3,       0);
        vecs[3]  = mk(0, 1,  10,    1,   0,    0,   -99, 0, 0, 0,      75);
        vecs[4]  = mk(0, 1,   7,    1,   0,    0,     0, 0, 0, 0,       7);
        vecs[5]  = mk(1, 1,   0,    0,   0,    0,  -300, 1, 1, 0,       0);
        vecs[6]  = mk(1, 1,   0,    0,   0,    0,  1000, 1, 1, 3,     125);
        vecs[7]  = mk(1, 1,   0,    0,   0,    0,  1000, 1, 1, 2,     250);
        vecs[8]  = mk(1, 1,   0,    0,   0,    0,  5000, 1, 1, 2,     255);
        vecs[9]  = mk(1, 1,   0,    0,   0,    0, -5000, 0, 1, 2,    -128);
        vecs[10] = mk(1, 1, 255, -128, 255, -128,     0, 0, 0, 0, -816000);
        vecs[11] = mk(1, 1,   0,    0,   0,    0,   101, 1, 1, 1,      51);
        vecs[12] = mk(1, 1,   0,    0,   0,    0,    -7, 0, 1, 1,      -3);
        vecs[13] = mk(1, 1,   0,    0,   0,    0,   300, 0, 1, 2,      75);
        vecs[14] = mk(1, 1,   0,    0,   0,    0,   -50, 1, 0, 0,       0);
        vecs[15] = mk(1, 1,   0,    0,   0,    0,   -50, 0, 0, 0,     -50);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        check("reset_pe_out", {32'd0, pe_out}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Latency and single-cycle out_valid for a lone pixel.
        exp_q.push_back(32'd25);
        drive_beat(1, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        @(negedge clk); check("lat_n1", {63'd0, out_valid}, 64'd0);
        @(negedge clk); check("lat_n2", {63'd0, out_valid}, 64'd0);
        @(negedge clk); check("lat_n3", {63'd0, out_valid}, 64'd1);
        @(negedge clk); check("lat_n4", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].last) exp_q.push_back(vecs[i].exp);
            drive_beat(vecs[i].first, vecs[i].last, vecs[i].a0, vecs[i].w0, vecs[i].fa,
                       vecs[i].fw, vecs[i].bias, vecs[i].relu, vecs[i].quan, vecs[i].sh);
        end
        wait_drain("table_drain");

        for (int i = 0; i < 8; i++) send_pixel_model(1 + int'($urandom_range(3)));
        wait_drain("random_drain");

        // Back-pressure: out_ready low for four cycles while six pixels stream in.
        base = n_out;
        for (int i = 0; i < 6; i++) b_vals[i] = i * 37 - 50;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    exp_q.push_back(b_vals[i] + 3 * (i + 1));
                    drive_beat(1, 1, 3, i + 1, 0, 0, b_vals[i], 0, 0, 0);
                end
            end
            begin
                g = 0;
                while (n_out < base + 1 && g < 100) begin
                    @(posedge clk);
                    g++;
                end
                #1 out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                    check("stall_out_valid", {63'd0, out_valid}, 64'd1);
                    check("stall_hold", {32'd0, pe_out}, {32'd0, exp_q[0]});
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(negedge clk);
                check("unstall_in_ready", {63'd0, in_ready}, 64'd1);
            end
        join
        wait_drain("bp_drain");
        check("bp_count", 64'(n_out - base), 64'd6);

        base = n_out;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(32'(i * 5));
            drive_beat(1, 1, i, 5, 0, 0, 0, 0, 0, 0);
        end
        wait_drain("stream_drain");
        check("stream_count", 64'(n_out - base), 64'd6);

        // Reset in the middle of a three-beat pixel discards the partial sum.
        drive_beat(1, 0, 200, 100, 10, 10, 1000, 0, 0, 0);
        drive_beat(0, 0, 200, 100, 10, 10, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        check("rst_mid_out_valid2", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.push_back(32'd9);
        drive_beat(1, 1, 9, 1, 0, 0, 0, 0, 0, 0);
        wait_drain("rst_drain");

        // Narrow accumulator: all taps 255 * -128 wraps in 16 bits.
        full16 = TAPS * 255 * (-128);
        e16 = full16[15:0];
        for (int k = 0; k < TAPS; k++) begin
            in_if[k*DW +: DW] = 8'hFF;
            in_w[k*WW +: WW]  = 8'h80;
        end
        bias16 = '0;
        in_valid16 = 1'b1;
        @(posedge clk);
        #1 in_valid16 = 1'b0;
        g = 0;
        while (!out_valid16 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("wrap16_valid", {63'd0, out_valid16}, 64'd1);
        check("wrap16_value", {48'd0, pe_out16}, {48'd0, e16});

        repeat (3) @(posedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
